mem_arbiter: RTL and testbench

Two-port burst arbiter that shares the single data-memory port between the instruction cache and the data cache of the MIPS pipeline. Each cache miss becomes a fixed-length, line-aligned burst. The arbiter grants one requester at a time with round-robin fairness and sequences the word addresses across the burst. It also routes write data, read data and per-beat acknowledges between the granted cache and memory. It sits between the two cache instances and the memory model, replacing the direct cache-to-memory wiring.

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I-cache / D-cache memory arbiter.
// Holds the burst geometry, the FSM state encoding, the requester IDs used by
// the round-robin pointer and the line-alignment helper.
package mem_arbiter_pkg;

  localparam int unsigned BURST = 4;   // words per line; power of two, >= 2
  localparam int unsigned AW    = 32;  // byte address width
  localparam int unsigned DW    = 32;  // data width

  localparam int unsigned BeatW = $clog2(BURST);
  // Byte-offset bits inside one line: word index plus the two byte bits.
  localparam int unsigned OffW  = BeatW + 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantI = 2'd1,
    StGrantD = 2'd2
  } state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

  // Clear the in-line offset so a burst always starts at word 0 of its line.
  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] addr);
    logic [AW-1:0] mask;
    mask           = '1;
    mask[OffW-1:0] = '0;
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the memory model.
//   I-cache : IReq, IAddr -> arbiter;  IAck, IRD <- arbiter
//   D-cache : DReq, DWE, DAddr, DWD -> arbiter;  DAck, DRD <- arbiter
//   memory  : MReq, MWE, MAddr, MWD <- arbiter;  MReady, MRD -> arbiter
// Modport slave is the arbiter's view; master is the caches-plus-memory view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IAck;
  logic [DW-1:0] IRD;

  logic          DReq;
  logic          DWE;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWD;
  logic          DAck;
  logic [DW-1:0] DRD;

  logic          MReq;
  logic          MWE;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MWD;
  logic          MReady;
  logic [DW-1:0] MRD;

  modport slave (
    input  IReq, IAddr, DReq, DWE, DAddr, DWD, MReady, MRD,
    output IAck, IRD, DAck, DRD, MReq, MWE, MAddr, MWD
  );

  modport master (
    output IReq, IAddr, DReq, DWE, DAddr, DWD, MReady, MRD,
    input  IAck, IRD, DAck, DRD, MReq, MWE, MAddr, MWD
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_i  : request vector, bit 0 = I-cache, bit 1 = D-cache
//   last_i : requester granted most recently
//   gnt_o  : one-hot grant, same bit mapping as req_i
module mem_arbiter_rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b00:   gnt_o = 2'b00;
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: the side that did not win last time gets it.
      default: gnt_o = (last_i == ReqI) ? 2'b10 : 2'b01;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing one memory port between the I-cache and D-cache.
//   CLK    : clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus_io : cache and memory handshake bundle (arbiter side)
// Each grant runs a fixed BURST-beat, line-aligned transfer; MReq, MWE and
// MAddr are registered, while MWD, the acks and read data are combinational
// from the grant state.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset,
  mem_arbiter_if.slave  bus_io
);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST - 1);

  state_e           state_q, state_d;
  req_id_e          last_q, last_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             mreq_q, mreq_d;
  logic             mwe_q, mwe_d;
  logic [AW-1:0]    maddr_q, maddr_d;
  logic [1:0]       gnt;

  mem_arbiter_rr_pick2 u_pick (
    .req_i  ({bus_io.DReq, bus_io.IReq}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;

    unique case (state_q)
      StIdle: begin
        if (gnt == 2'b10) begin
          state_d = StGrantD;
          mreq_d  = 1'b1;
          mwe_d   = bus_io.DWE;
          maddr_d = line_base(bus_io.DAddr);
          beat_d  = '0;
        end else if (gnt == 2'b01) begin
          state_d = StGrantI;
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = line_base(bus_io.IAddr);
          beat_d  = '0;
        end
      end

      StGrantI, StGrantD: begin
        // Requests are not looked at here: a started burst always completes.
        if (bus_io.MReady) begin
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            last_d  = (state_q == StGrantD) ? ReqD : ReqI;
            beat_d  = '0;
            mreq_d  = 1'b0;
            mwe_d   = 1'b0;
            maddr_d = '0;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            // Base is line-aligned, so stepping by one word equals base + 4*beat.
            maddr_d = maddr_q + AW'(4);
          end
        end
      end

      default: begin
        state_d = StIdle;
        mreq_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      last_q  <= ReqI;
      beat_q  <= '0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
    end
  end

  assign bus_io.MReq  = mreq_q;
  assign bus_io.MWE   = mwe_q;
  assign bus_io.MAddr = maddr_q;
  assign bus_io.MWD   = (state_q == StGrantD) ? bus_io.DWD : '0;
  assign bus_io.IAck  = bus_io.MReady & (state_q == StGrantI);
  assign bus_io.DAck  = bus_io.MReady & (state_q == StGrantD);
  assign bus_io.IRD   = bus_io.MRD;
  assign bus_io.DRD   = bus_io.MRD;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table driven with a
// manual MReady, plus sequences against a small latency-programmable memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [31:0] RdKey = 32'h5A5A_0000;  // memory returns MAddr ^ RdKey

  logic        clk;
  logic        rst_n;
  logic        mem_on, mem_rdy, man_rdy, dwd_auto;
  int          mem_lat;
  int          wd_idx;
  logic [31:0] dwd_man;
  logic [31:0] wd_tab [8];
  int          n_cmp, n_bad;

  typedef struct {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } beat_t;
  beat_t beats_q[$];

  typedef struct {
    logic        ireq, dreq, dwe, rdy;
    logic [31:0] dwd;
    logic        mreq, mwe, chk_a;
    logic [31:0] maddr, mwd;
    logic        iack, dack;
  } vec_t;
  vec_t tab [15];

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .CLK    (clk),
    .Reset  (rst_n),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.MReady = mem_on ? mem_rdy : man_rdy;
  assign bus.MRD    = bus.MAddr ^ RdKey;
  assign bus.DWD    = dwd_auto ? wd_tab[wd_idx[2:0]] : dwd_man;

  // Memory: counts request cycles seen at edges; MReady after mem_lat of them.
  initial begin
    int   w;
    logic s_req, s_rdy;
    w = 0;
    mem_rdy = 1'b0;
    forever begin
      @(negedge clk);
      s_req = bus.MReq;
      s_rdy = bus.MReady;
      @(posedge clk);
      #1;
      if (s_rdy) w = 0;
      if (s_req) w = w + 1;
      else w = 0;
      mem_rdy = mem_on && bus.MReq && (w == mem_lat);
    end
  end

  // D-cache write data advances after each DAck.
  initial begin
    logic s;
    forever begin
      @(negedge clk);
      s = bus.DAck;
      @(posedge clk);
      #1;
      if (s) wd_idx = wd_idx + 1;
    end
  end

  // Beat log.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (bus.IAck || bus.DAck) begin
        b.d    = bus.DAck;
        b.we   = bus.MWE;
        b.addr = bus.MAddr;
        b.wd   = bus.MWD;
        b.rd   = bus.DAck ? bus.DRD : bus.IRD;
        beats_q.push_back(b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (beats_q.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk32({nm, " beat count"}, 32'(beats_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    bus.DWE  = 1'b0;
    mem_on   = 1'b0;
    man_rdy  = 1'b0;
    dwd_auto = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats_q.delete();
  endtask

  function automatic vec_t mk(input logic ireq, dreq, dwe, rdy, input logic [31:0] dwd,
                              input logic mreq, mwe, chk_a, input logic [31:0] maddr, mwd,
                              input logic iack, dack);
    vec_t v;
    v.ireq = ireq;   v.dreq = dreq;   v.dwe = dwe;     v.rdy = rdy;  v.dwd = dwd;
    v.mreq = mreq;   v.mwe = mwe;     v.chk_a = chk_a; v.maddr = maddr;
    v.mwd = mwd;     v.iack = iack;   v.dack = dack;
    return v;
  endfunction

  initial begin
    int started, idle, act, unstable;
    logic [31:0] pa;
    logic pm, pack;

    n_cmp = 0;  n_bad = 0;
    mem_on = 1'b0;  man_rdy = 1'b0;  dwd_auto = 1'b0;  dwd_man = '0;
    mem_lat = 1;  wd_idx = 0;
    wd_tab = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11};
    bus.IReq = 1'b0;  bus.DReq = 1'b0;  bus.DWE = 1'b0;  bus.IAddr = '0;  bus.DAddr = '0;

    //          ireq dreq dwe rdy dwd     mreq mwe chka maddr   mwd    iack dack
    tab[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 1'b0, 1'b0);
    tab[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 1'b0, 1'b0);
    tab[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    tab[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0);
    tab[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h14, 32'h0, 1'b1, 1'b0);
    tab[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 1'b1, 32'h18, 32'h0, 1'b0, 1'b0);
    tab[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h18, 32'h0, 1'b1, 1'b0);
    tab[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h1C, 32'h0, 1'b1, 1'b0);
    tab[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0);
    tab[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0A, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA, 1'b0, 1'b0);
    tab[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0A, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA, 1'b0, 1'b1);
    tab[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0B, 1'b1, 1'b1, 1'b1, 32'h44, 32'hB, 1'b0, 1'b1);
    tab[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h48, 32'hC, 1'b0, 1'b1);
    tab[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0D, 1'b1, 1'b1, 1'b1, 32'h4C, 32'hD, 1'b0, 1'b1);
    tab[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0E, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0);

    // Reset held with IReq high and MReady forced: nothing may be granted.
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    bus.IReq  = 1'b1;
    bus.IAddr = 32'h14;
    man_rdy   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk1("reset MReq", bus.MReq, 1'b0);
      chk1("reset IAck", bus.IAck, 1'b0);
    end
    chk1("reset MWE", bus.MWE, 1'b0);
    chk32("reset MAddr", bus.MAddr, 32'h0);
    chk32("reset MWD", bus.MWD, 32'h0);
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    mem_lat = 1;
    mem_on  = 1'b1;
    beats_q.delete();
    rst_n   = 1'b1;
    wait_beats(4, 40, "I burst");
    @(posedge clk);
    #1;
    bus.IReq = 1'b0;
    @(negedge clk);
    #1;
    chk1("I burst idle after", bus.MReq, 1'b0);
    repeat (3) @(negedge clk);
    chk32("I burst ack total", 32'(beats_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beats_q.size()) begin
        chk1($sformatf("I beat%0d who", i), beats_q[i].d, 1'b0);
        chk32($sformatf("I beat%0d addr", i), beats_q[i].addr, 32'h10 + 32'(4 * i));
        chk32($sformatf("I beat%0d rd", i), beats_q[i].rd, (32'h10 + 32'(4 * i)) ^ RdKey);
      end
    end

    // Cycle-by-cycle vectors with manually driven MReady.
    do_reset();
    bus.IAddr = 32'h14;
    bus.DAddr = 32'h40;
    foreach (tab[i]) begin
      @(posedge clk);
      #1;
      bus.IReq = tab[i].ireq;
      bus.DReq = tab[i].dreq;
      bus.DWE  = tab[i].dwe;
      man_rdy  = tab[i].rdy;
      dwd_man  = tab[i].dwd;
      @(negedge clk);
      chk1($sformatf("tab%0d MReq", i), bus.MReq, tab[i].mreq);
      chk1($sformatf("tab%0d MWE", i), bus.MWE, tab[i].mwe);
      chk32($sformatf("tab%0d MWD", i), bus.MWD, tab[i].mwd);
      chk1($sformatf("tab%0d IAck", i), bus.IAck, tab[i].iack);
      chk1($sformatf("tab%0d DAck", i), bus.DAck, tab[i].dack);
      if (tab[i].chk_a) chk32($sformatf("tab%0d MAddr", i), bus.MAddr, tab[i].maddr);
      if (tab[i].iack) chk32($sformatf("tab%0d IRD", i), bus.IRD, tab[i].maddr ^ RdKey);
      if (tab[i].dack) chk32($sformatf("tab%0d DRD", i), bus.DRD, tab[i].maddr ^ RdKey);
    end

    // Both requesters held from reset release: D, I, D, I with one idle cycle between.
    do_reset();
    bus.IAddr = 32'h100;
    bus.DAddr = 32'h204;
    bus.DWE   = 1'b0;
    bus.IReq  = 1'b1;
    bus.DReq  = 1'b1;
    mem_lat   = 1;
    mem_on    = 1'b1;
    started = 0;
    idle    = 0;
    for (int c = 0; c < 200 && beats_q.size() < 16; c++) begin
      @(negedge clk);
      #1;
      if (bus.MReq) started = 1;
      else if (started != 0) idle++;
    end
    @(posedge clk);
    #1;
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    chk32("tie beat count", 32'(beats_q.size()), 32'd16);
    chk32("tie idle cycles", 32'(idle), 32'd3);
    for (int i = 0; i < 16; i++) begin
      if (i < beats_q.size()) begin
        chk1($sformatf("tie beat%0d who", i), beats_q[i].d, ((i / 4) % 2) == 0);
        chk32($sformatf("tie beat%0d addr", i), beats_q[i].addr,
              (((i / 4) % 2) == 0 ? 32'h200 : 32'h100) + 32'(4 * (i % 4)));
      end
    end

    // Slow memory: 1 + 4*3 request cycles, address steady while waiting.
    do_reset();
    bus.IAddr = 32'h2000;
    mem_lat   = 3;
    mem_on    = 1'b1;
    bus.IReq  = 1'b1;
    act = 0;  unstable = 0;  pa = '0;  pm = 1'b0;  pack = 1'b0;
    for (int c = 0; c < 80 && beats_q.size() < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.MReq) act++;
      if (bus.MReq && pm && !pack && bus.MAddr != pa) unstable++;
      pa   = bus.MAddr;
      pm   = bus.MReq;
      pack = bus.IAck;
    end
    @(posedge clk);
    #1;
    bus.IReq = 1'b0;
    @(negedge clk);
    chk32("slow beat count", 32'(beats_q.size()), 32'd4);
    chk32("slow active cycles", 32'(act), 32'd13);
    chk32("slow addr changes", 32'(unstable), 32'd0);
    chk1("slow bubble", bus.MReq, 1'b0);
    if (beats_q.size() == 4) chk32("slow last addr", beats_q[3].addr, 32'h200C);

    // Reset in the middle of a write burst, then a fresh write burst.
    do_reset();
    bus.DAddr = 32'h80;
    bus.DWE   = 1'b1;
    bus.DReq  = 1'b1;
    wd_idx    = 0;
    dwd_auto  = 1'b1;
    mem_lat   = 1;
    mem_on    = 1'b1;
    wait_beats(2, 40, "abort pre");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort MReq", bus.MReq, 1'b0);
    chk1("abort MWE", bus.MWE, 1'b0);
    chk1("abort DAck", bus.DAck, 1'b0);
    bus.DReq = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats_q.delete();
    wd_idx    = 0;
    bus.DAddr = 32'h30C;
    bus.DReq  = 1'b1;
    wait_beats(4, 40, "restart");
    @(posedge clk);
    #1;
    bus.DReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < beats_q.size()) begin
        chk1($sformatf("restart beat%0d we", i), beats_q[i].we, 1'b1);
        chk32($sformatf("restart beat%0d addr", i), beats_q[i].addr, 32'h300 + 32'(4 * i));
        chk32($sformatf("restart beat%0d wd", i), beats_q[i].wd, 32'hA + 32'(i));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
